// File: rtl/morse_pkg.sv
// Shared state type and Morse timing constants for the keyer and its unit timer.
`timescale 1ns/1ps
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        GAP
    } state_t;

    localparam logic DOT            = 1'b1;
    localparam logic DASH           = 1'b0;
    localparam int   ELEMENTS       = 5;
    localparam int   DASH_UNITS     = 3;
    localparam int   ELEM_GAP_UNITS = 1;

    // Length of one keyed element in Morse units.
    function automatic int mark_units(input logic element);
        return (element == DASH) ? DASH_UNITS : 1;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter that paces every keyer state; expired while the count sits at zero.
`timescale 1ns/1ps
module morse_unit_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Holds at zero instead of wrapping so an idle keyer never sees a stale duration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/morse_keyer.sv
// Serial Morse keyer for one 5-element code word with standard unit timing.
// Optional sidetone output enabled by defining MORSE_KEYER_SIDETONE_EN.
`timescale 1ns/1ps
module morse_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES      = 4,
    parameter int CHAR_GAP_UNITS   = 3,
    parameter int TONE_HALF_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] code_in,
    input  logic       valid,
    output logic       ready,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic       tone_out
);

    localparam int TIMER_W = $clog2(DASH_UNITS * UNIT_CYCLES * CHAR_GAP_UNITS + 1);
    localparam logic [TIMER_W-1:0] SPACE_LOAD = TIMER_W'(ELEM_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);

    state_t             state;
    logic [4:0]         code;
    logic [2:0]         elem_idx;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_expired;

    function automatic logic [TIMER_W-1:0] mark_load(input logic element);
        return TIMER_W'(mark_units(element) * UNIT_CYCLES - 1);
    endfunction

    // The timer is reloaded on the same edge that the FSM enters its next timed state.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            IDLE: begin
                timer_load  = valid;
                timer_value = mark_load(code_in[ELEMENTS-1]);
            end
            MARK: begin
                timer_load  = timer_expired;
                timer_value = (elem_idx != 3'd0) ? SPACE_LOAD : GAP_LOAD;
            end
            SPACE: begin
                timer_load  = timer_expired;
                timer_value = mark_load(code[elem_idx - 3'd1]);
            end
            default: begin
                timer_load  = 1'b0;
                timer_value = '0;
            end
        endcase
    end

    morse_unit_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (timer_load),
        .value   (timer_value),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            key_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            code     <= '0;
            elem_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        code     <= code_in;
                        elem_idx <= 3'(ELEMENTS - 1);
                        state    <= MARK;
                        key_out  <= 1'b1;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MARK: begin
                    if (timer_expired) begin
                        key_out <= 1'b0;
                        state   <= (elem_idx != 3'd0) ? SPACE : GAP;
                    end
                end
                SPACE: begin
                    if (timer_expired) begin
                        elem_idx <= elem_idx - 3'd1;
                        key_out  <= 1'b1;
                        state    <= MARK;
                    end
                end
                GAP: begin
                    if (timer_expired) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MORSE_KEYER_SIDETONE_EN
    localparam int TONE_W = $clog2(TONE_HALF_CYCLES + 1);

    logic [TONE_W-1:0] tone_count;
    logic              tone;
    logic              mark_entry;

    assign mark_entry = timer_load && ((state == IDLE) || (state == SPACE));

    // Every mark starts its tone low; the last mark cycle clears it for the following silence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tone       <= 1'b0;
            tone_count <= '0;
        end else if (mark_entry) begin
            tone       <= 1'b0;
            tone_count <= TONE_W'(TONE_HALF_CYCLES - 1);
        end else if ((state == MARK) && !timer_expired) begin
            if (tone_count == '0) begin
                tone       <= ~tone;
                tone_count <= TONE_W'(TONE_HALF_CYCLES - 1);
            end else begin
                tone_count <= tone_count - 1'b1;
            end
        end else begin
            tone       <= 1'b0;
            tone_count <= '0;
        end
    end

    assign tone_out = tone;
`else
    assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: per-cycle waveform reference built from Morse unit rules, plus character-length check.
`timescale 1ns/1ps
module tb_morse_keyer;

    localparam int UNIT      = 4;
    localparam int CHAR_GAP  = 3;
    localparam int TONE_HALF = 2;

    logic       clk;
    logic       reset_n;
    logic [4:0] code_in;
    logic       valid;
    logic       ready;
    logic       key_out;
    logic       busy;
    logic       done;
    logic       tone_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit q_key[$];
    bit q_tone[$];
    bit exp_done     = 1'b0;
    bit len_pending  = 1'b0;
    int acc_cyc      = 0;
    int exp_len      = 0;

    morse_keyer #(
        .UNIT_CYCLES      (UNIT),
        .CHAR_GAP_UNITS   (CHAR_GAP),
        .TONE_HALF_CYCLES (TONE_HALF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .code_in  (code_in),
        .valid    (valid),
        .ready    (ready),
        .key_out  (key_out),
        .busy     (busy),
        .done     (done),
        .tone_out (tone_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, observed, expected);
        end
    endtask

    // Expected key/tone level for every cycle of one character, first mark cycle first.
    function automatic void build_char(input logic [4:0] c);
        int len;
        int marks;
        marks = 0;
        for (int i = 4; i >= 0; i--) begin
            len = (c[i] ? 1 : 3) * UNIT;
            marks += (c[i] ? 1 : 3);
            for (int j = 0; j < len; j++) begin
                q_key.push_back(1'b1);
                q_tone.push_back(((j / TONE_HALF) % 2) == 1);
            end
            if (i > 0) begin
                for (int j = 0; j < UNIT; j++) begin
                    q_key.push_back(1'b0);
                    q_tone.push_back(1'b0);
                end
            end
        end
        for (int j = 0; j < CHAR_GAP * UNIT; j++) begin
            q_key.push_back(1'b0);
            q_tone.push_back(1'b0);
        end
        exp_len = UNIT * (marks + 4 + CHAR_GAP);
    endfunction

    task automatic checkAll();
        bit exp_key;
        bit exp_tone;
        bit exp_busy;
        exp_busy = (q_key.size() > 0);
        exp_key  = exp_busy ? q_key[0] : 1'b0;
`ifdef MORSE_KEYER_SIDETONE_EN
        exp_tone = exp_busy ? q_tone[0] : 1'b0;
`else
        exp_tone = 1'b0;
`endif
        checkOutput("key_out",  32'(key_out),  32'(exp_key));
        checkOutput("ready",    32'(ready),    32'(!exp_busy));
        checkOutput("busy",     32'(busy),     32'(exp_busy));
        checkOutput("done",     32'(done),     32'(exp_done));
        checkOutput("tone_out", 32'(tone_out), 32'(exp_tone));
        if (done && len_pending) begin
            checkOutput("charlen", 32'(cyc - acc_cyc), 32'(exp_len));
            len_pending = 1'b0;
        end
    endtask

    // Drive one cycle of inputs from the falling edge, advance the reference at the rising edge, compare just after.
    task automatic applyStimulus(input logic v, input logic [4:0] c);
        bit dummy;
        valid   = v;
        code_in = c;
        @(posedge clk);
        cyc++;
        if (q_key.size() > 0) begin
            dummy    = q_key.pop_front();
            dummy    = q_tone.pop_front();
            exp_done = (q_key.size() == 0);
        end else begin
            exp_done = 1'b0;
            if (v) begin
                build_char(c);
                acc_cyc     = cyc;
                len_pending = 1'b1;
            end
        end
        #1;
        checkAll();
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = q_key.size() + 3;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'($urandom));
    endtask

    initial begin
        reset_n = 1'b0;
        valid   = 1'b0;
        code_in = 5'b00000;
        #12;
        checkAll();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed words: digit 5, digit 0, digit 1.
        applyStimulus(1'b1, 5'b11111);
        drain();
        applyStimulus(1'b1, 5'b00000);
        drain();
        applyStimulus(1'b1, 5'b10000);
        drain();

        // Valid held with the code changed mid-character: only the done cycle takes the new word.
        applyStimulus(1'b1, 5'b10000);
        repeat (150) applyStimulus(1'b1, 5'b11000);
        drain();

        // Randomized traffic, including back-to-back and codes wiggling while busy.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(3) != 0), 5'($urandom));
        end
        drain();

        // Asynchronous reset during the second mark of digit 5.
        applyStimulus(1'b1, 5'b11111);
        repeat (9) applyStimulus(1'b0, 5'b00000);
        #2;
        reset_n = 1'b0;
        #1;
        q_key.delete();
        q_tone.delete();
        exp_done    = 1'b0;
        len_pending = 1'b0;
        checkOutput("rst_key_out", 32'(key_out), 32'd0);
        checkOutput("rst_ready",   32'(ready),   32'd1);
        checkOutput("rst_busy",    32'(busy),    32'd0);
        checkOutput("rst_done",    32'(done),    32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (100) applyStimulus(1'b0, 5'($urandom));
        applyStimulus(1'b1, 5'b01010);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
